// File: rtl/ram2e_banked.sv
// Apple IIe aux-slot DRAM/bank controller: sequences nRAS/nCAS/RA from C14M against PHI0/PHI1.
// Define RAM2E_BANKREAD_EN to add bank-register readback through the $C07X BANK_RD offset.
module ram2e_banked #(
  parameter int unsigned BA_W       = 6,
  parameter int unsigned RA_W       = 4,
  parameter int unsigned REF_PERIOD = 13,
  parameter logic [3:0]  BANK_WR    = 4'h3,
  parameter logic [3:0]  BANK_RD    = 4'hB
) (
  input  logic            C14M,
  input  logic            RST,
  input  logic            PHI1,
  input  logic            nPRAS,
  input  logic            nWE,
  input  logic            nWE80,
  input  logic            nEN80,
  input  logic            nC07X,
  input  logic [7:0]      MA,
  inout  wire  [7:0]      MD,
  inout  wire  [7:0]      RD,
  output wire  [7:0]      VD,
  output logic            nRAS,
  output logic            nCAS,
  output logic            nRWE,
  output logic [RA_W-1:0] RA
);

  localparam int unsigned LoW  = BA_W / 2;
  localparam int unsigned RefW = $clog2(REF_PERIOD);
  localparam logic [RefW-1:0] RefLast = RefW'(REF_PERIOD - 1);
  localparam logic [BA_W-1:0] LoMask  = BA_W'((1 << LoW) - 1);

  logic            phi1_q, phi1_d;
  logic            phi0_seen_q, phi0_seen_d;
  logic [3:0]      s_q, s_d;
  logic [RefW-1:0] ref_q, ref_d;
  logic            nras_q, nras_d;
  logic            ncas_q, ncas_d;
  logic [RA_W-1:0] ra_q, ra_d;
  logic            wrsel_q, wrsel_d;
  logic [BA_W-1:0] ba_q, ba_d;
  logic [7:0]      vdr_q, vdr_d;

  logic            en80;
  logic            sync;
  logic [RA_W-1:0] ra_hi, ra_lo;

  assign en80 = ~nEN80;
  // A PHI1 rise only counts once a PHI0 phase has been seen since reset.
  assign sync = PHI1 & ~phi1_q & phi0_seen_q;

  assign ra_hi = RA_W'(ba_q >> LoW);
  assign ra_lo = RA_W'(ba_q & LoMask);

  always_comb begin
    phi1_d      = PHI1;
    phi0_seen_d = phi0_seen_q | ~PHI1;
  end

  always_comb begin
    s_d = s_q;
    if (sync) begin
      s_d = 4'd1;
    end else if (s_q != 4'd0 && s_q != 4'd15) begin
      s_d = s_q + 4'd1;
    end
  end

  always_comb begin
    ref_d = ref_q;
    if (s_q == 4'd1) begin
      ref_d = (ref_q == RefLast) ? '0 : ref_q + 1'b1;
    end
  end

  always_comb begin
    nras_d = 1'b1;
    case (s_q)
      4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10: nras_d = 1'b0;
      4'd5:                                nras_d = (ref_q != '0);
      default:                             nras_d = 1'b1;
    endcase
    if (sync) begin
      nras_d = 1'b0;
    end
  end

  always_comb begin
    ncas_d = ncas_q;
    case (s_q)
      4'd2, 4'd4, 4'd10: ncas_d = 1'b0;
      default:           ncas_d = ncas_q;
    endcase
    if (s_q == 4'd0 || s_q == 4'd3 || nPRAS) begin
      ncas_d = 1'b1;
    end
  end

  always_comb begin
    ra_d = '0;
    case (s_q)
      4'd6, 4'd7, 4'd8: ra_d = ra_hi;
      4'd9, 4'd10:      ra_d = ra_lo;
      default:          ra_d = '0;
    endcase
  end

  always_comb begin
    wrsel_d = wrsel_q;
    ba_d    = ba_q;
    vdr_d   = vdr_q;
    if (s_q == 4'd7) begin
      wrsel_d = ~nC07X & (MA[3:0] == BANK_WR) & ~nWE;
    end
    if (s_q == 4'd13 && wrsel_q) begin
      ba_d = MD[BA_W-1:0];
    end
    if (s_q == 4'd3) begin
      vdr_d = RD;
    end
  end

  always_ff @(posedge C14M) begin
    if (RST) begin
      phi1_q      <= 1'b0;
      phi0_seen_q <= 1'b0;
      s_q         <= 4'd0;
      ref_q       <= '0;
      nras_q      <= 1'b1;
      ncas_q      <= 1'b1;
      ra_q        <= '0;
      wrsel_q     <= 1'b0;
      ba_q        <= '0;
      vdr_q       <= 8'h00;
    end else begin
      phi1_q      <= phi1_d;
      phi0_seen_q <= phi0_seen_d;
      s_q         <= s_d;
      ref_q       <= ref_d;
      nras_q      <= nras_d;
      ncas_q      <= ncas_d;
      ra_q        <= ra_d;
      wrsel_q     <= wrsel_d;
      ba_q        <= ba_d;
      vdr_q       <= vdr_d;
    end
  end

  assign nRAS = nras_q;
  assign nCAS = ncas_q;
  assign RA   = ra_q;
  assign nRWE = nWE80;
  assign VD   = PHI1 ? 8'bz : vdr_q;
  assign RD   = (en80 & nWE) ? MD : 8'bz;

`ifdef RAM2E_BANKREAD_EN
  logic rdsel_q, rdsel_d;
  logic md_bank_oe;

  always_comb begin
    rdsel_d = rdsel_q;
    if (s_q == 4'd7) begin
      rdsel_d = ~nC07X & (MA[3:0] == BANK_RD) & nWE;
    end
    if (sync) begin
      rdsel_d = 1'b0;
    end
  end

  always_ff @(posedge C14M) begin
    if (RST) begin
      rdsel_q <= 1'b0;
    end else begin
      rdsel_q <= rdsel_d;
    end
  end

  // Readback window S8..S14 overrides the RD->MD path.
  assign md_bank_oe = rdsel_q & (s_q >= 4'd8) & (s_q <= 4'd14);
  assign MD = md_bank_oe ? 8'(ba_q) : ((en80 & ~nWE) ? RD : 8'bz);
`else
  logic unused_bank_rd;
  assign unused_bank_rd = ^BANK_RD;
  assign MD = (en80 & ~nWE) ? RD : 8'bz;
`endif

  logic unused_bits;
  assign unused_bits = ^{MA[7:4], MD};

endmodule
